// File: rtl/cmp_latch_bank_if.sv
// Bus bundle for cmp_latch_bank: per-channel comparator inputs, control,
// committed decisions, edge pulses and packed toggle counters.
interface cmp_latch_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic                      en;
  logic                      clr_cnt;
  logic [CHANNELS-1:0]       vip;
  logic [CHANNELS-1:0]       vin;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       valid;
  logic [CHANNELS-1:0]       rise;
  logic [CHANNELS-1:0]       fall;
  logic [CHANNELS*CNT_W-1:0] toggle_cnt;

  modport master (
    output en, clr_cnt, vip, vin,
    input  out, valid, rise, fall, toggle_cnt
  );

  modport slave (
    input  en, clr_cnt, vip, vin,
    output out, valid, rise, fall, toggle_cnt
  );
endinterface

// File: rtl/cmp_latch_bank.sv
// Multi-channel clocked latching comparator: synchronise vip/vin, filter the
// decision over FILTER_LEN edges, hold on equal inputs, report edges and counts.
module cmp_latch_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  cmp_latch_bank_if.slave bus
);
  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  typedef logic [RUN_W-1:0] run_t;
  localparam run_t RUN_FULL = run_t'(FILTER_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sp_p0, sn_p0;
    logic                   sp, sn;
    logic                   has_cand, cand, brk, restart, commit;
    run_t                   run_p1, run_next;
    logic                   pend_p1;
    logic                   out_q, valid_q, rise_q, fall_q;
    logic [CNT_W-1:0]       cnt_q;

    // Stage p0: input synchronisers (shift in at bit 0, sample at the top)
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sp_p0 <= '0;
        sn_p0 <= '0;
      end else begin
        sp_p0 <= {sp_p0[SYNC_STAGES-2:0], bus.vip[i]};
        sn_p0 <= {sn_p0[SYNC_STAGES-2:0], bus.vin[i]};
      end
    end

    assign sp = sp_p0[SYNC_STAGES-1];
    assign sn = sn_p0[SYNC_STAGES-1];

    // A zero run means the previous edge broke it, so the next candidate starts fresh
    always_comb begin
      has_cand = sp ^ sn;
      cand     = sp;
      brk      = !has_cand || (valid_q && (cand == out_q)) || !bus.en;
      restart  = (cand != pend_p1) || (run_p1 == '0);
      run_next = restart ? run_t'(1) : run_p1 + run_t'(1);
      commit   = !brk && (run_next == RUN_FULL);
    end

    // Stage p1: filter run, committed decision, pulses and toggle counter
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        run_p1  <= '0;
        pend_p1 <= 1'b0;
        out_q   <= 1'b0;
        valid_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (brk) begin
          run_p1 <= '0;
        end else begin
          pend_p1 <= cand;
          if (commit) begin
            out_q   <= cand;
            valid_q <= 1'b1;
            rise_q  <= cand;
            fall_q  <= !cand && valid_q;
            run_p1  <= '0;
          end else begin
            run_p1 <= run_next;
          end
        end
        // Clear has priority over a coincident increment
        if (bus.clr_cnt)
          cnt_q <= '0;
        else if (commit && (cand || valid_q))
          cnt_q <= sat_inc(cnt_q);
      end
    end

    assign bus.out[i]                      = out_q;
    assign bus.valid[i]                    = valid_q;
    assign bus.rise[i]                     = rise_q;
    assign bus.fall[i]                     = fall_q;
    assign bus.toggle_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
endmodule

// File: tb/tb_cmp_latch_bank.sv
// Directed bench for cmp_latch_bank: default instance plus a FILTER_LEN=1,
// CNT_W=2 instance for counter saturation and clear priority.
module tb_cmp_latch_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cmp_latch_bank_if #(.CHANNELS(4), .CNT_W(8)) m_if ();
  cmp_latch_bank_if #(.CHANNELS(4), .CNT_W(2)) s_if ();

  cmp_latch_bank #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave)
  );

  cmp_latch_bank #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(s_if.slave)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    m_if.en = 1'b1; m_if.clr_cnt = 1'b0; m_if.vip = '0; m_if.vin = '0;
    s_if.en = 1'b1; s_if.clr_cnt = 1'b0; s_if.vip = '0; s_if.vin = '0;
    rst = 1'b1;
    step(2);
    vectors++; if (m_if.out !== 4'b0000) begin miscompares++; $display("FAIL reset_out: got %b expected %b", m_if.out, 4'b0000); end
    vectors++; if (m_if.valid !== 4'b0000) begin miscompares++; $display("FAIL reset_valid: got %b expected %b", m_if.valid, 4'b0000); end
    vectors++; if ((m_if.rise | m_if.fall) !== 4'b0000) begin miscompares++; $display("FAIL reset_pulses: got %b expected %b", m_if.rise | m_if.fall, 4'b0000); end
    vectors++; if (m_if.toggle_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %h expected %h", m_if.toggle_cnt, 32'h0); end
    rst = 1'b0;
    step(1);
    m_if.vip[0] = 1'b1; m_if.vin[0] = 1'b0;
    step(5);
    vectors++; if (m_if.out[0] !== 1'b0) begin miscompares++; $display("FAIL ch0_early: got %b expected %b", m_if.out[0], 1'b0); end
    step(1);
    vectors++; if (m_if.out !== 4'b0001) begin miscompares++; $display("FAIL ch0_out: got %b expected %b", m_if.out, 4'b0001); end
    vectors++; if (m_if.rise !== 4'b0001) begin miscompares++; $display("FAIL ch0_rise: got %b expected %b", m_if.rise, 4'b0001); end
    vectors++; if (m_if.valid !== 4'b0001) begin miscompares++; $display("FAIL ch0_valid: got %b expected %b", m_if.valid, 4'b0001); end
    vectors++; if (m_if.toggle_cnt[7:0] !== 8'd1) begin miscompares++; $display("FAIL ch0_cnt: got %0d expected %0d", m_if.toggle_cnt[7:0], 1); end
    step(1);
    vectors++; if (m_if.rise[0] !== 1'b0) begin miscompares++; $display("FAIL ch0_rise_width: got %b expected %b", m_if.rise[0], 1'b0); end
  endtask

  task automatic test_glitch;
    logic bad;
    m_if.vip[1] = 1'b1; m_if.vin[1] = 1'b0;
    step(6);
    vectors++; if (m_if.out[1] !== 1'b1) begin miscompares++; $display("FAIL ch1_commit: got %b expected %b", m_if.out[1], 1'b1); end
    step(2);
    m_if.vip[1] = 1'b0; m_if.vin[1] = 1'b1;
    step(3);
    m_if.vip[1] = 1'b1; m_if.vin[1] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (m_if.out[1] !== 1'b1 || m_if.fall[1] !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL ch1_glitch_reject: got %b expected %b", bad, 1'b0); end
    m_if.vip[1] = 1'b0; m_if.vin[1] = 1'b1;
    step(5);
    vectors++; if (m_if.out[1] !== 1'b1) begin miscompares++; $display("FAIL ch1_fall_early: got %b expected %b", m_if.out[1], 1'b1); end
    step(1);
    vectors++; if (m_if.out[1] !== 1'b0) begin miscompares++; $display("FAIL ch1_out_fall: got %b expected %b", m_if.out[1], 1'b0); end
    vectors++; if (m_if.fall !== 4'b0010) begin miscompares++; $display("FAIL ch1_fall_pulse: got %b expected %b", m_if.fall, 4'b0010); end
    vectors++; if (m_if.toggle_cnt[15:8] !== 8'd2) begin miscompares++; $display("FAIL ch1_cnt: got %0d expected %0d", m_if.toggle_cnt[15:8], 2); end
    step(1);
    vectors++; if (m_if.fall[1] !== 1'b0) begin miscompares++; $display("FAIL ch1_fall_width: got %b expected %b", m_if.fall[1], 1'b0); end
  endtask

  task automatic test_hold;
    logic bad;
    m_if.vip[2] = 1'b1; m_if.vin[2] = 1'b0;
    step(6);
    vectors++; if (m_if.out[2] !== 1'b1) begin miscompares++; $display("FAIL ch2_commit: got %b expected %b", m_if.out[2], 1'b1); end
    m_if.vin[2] = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (m_if.out[2] !== 1'b1 || m_if.rise[2] !== 1'b0 || m_if.fall[2] !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL ch2_hold_high: got %b expected %b", bad, 1'b0); end
    m_if.vip[2] = 1'b0; m_if.vin[2] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (m_if.out[2] !== 1'b1 || m_if.rise[2] !== 1'b0 || m_if.fall[2] !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL ch2_hold_low: got %b expected %b", bad, 1'b0); end
    vectors++; if (m_if.toggle_cnt[23:16] !== 8'd1) begin miscompares++; $display("FAIL ch2_cnt: got %0d expected %0d", m_if.toggle_cnt[23:16], 1); end
  endtask

  task automatic test_enable;
    logic bad;
    m_if.vip[3] = 1'b1; m_if.vin[3] = 1'b0;
    step(3);
    m_if.en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (m_if.out !== 4'b0101 || m_if.rise !== 4'b0000 || m_if.fall !== 4'b0000) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL en_gate_hold: got %b expected %b", bad, 1'b0); end
    vectors++; if (m_if.valid[3] !== 1'b0) begin miscompares++; $display("FAIL en_gate_valid: got %b expected %b", m_if.valid[3], 1'b0); end
    m_if.en = 1'b1;
    step(3);
    vectors++; if (m_if.out[3] !== 1'b0) begin miscompares++; $display("FAIL en_reenable_early: got %b expected %b", m_if.out[3], 1'b0); end
    step(1);
    vectors++; if (m_if.out[3] !== 1'b1) begin miscompares++; $display("FAIL en_reenable_out: got %b expected %b", m_if.out[3], 1'b1); end
    vectors++; if (m_if.rise !== 4'b1000) begin miscompares++; $display("FAIL en_reenable_rise: got %b expected %b", m_if.rise, 4'b1000); end
  endtask

  task automatic test_saturation;
    int exp_c[5] = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      s_if.vip[3] = (i % 2 == 0); s_if.vin[3] = (i % 2 != 0);
      step(3);
      vectors++; if (s_if.out[3] !== (i % 2 == 0)) begin miscompares++; $display("FAIL sat_out_%0d: got %b expected %b", i, s_if.out[3], (i % 2 == 0)); end
      vectors++; if (int'(s_if.toggle_cnt[7:6]) !== exp_c[i]) begin miscompares++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, s_if.toggle_cnt[7:6], exp_c[i]); end
    end
    vectors++; if (s_if.valid !== 4'b1000) begin miscompares++; $display("FAIL sat_valid: got %b expected %b", s_if.valid, 4'b1000); end
    s_if.vip[3] = 1'b0; s_if.vin[3] = 1'b1;
    step(2);
    s_if.clr_cnt = 1'b1;
    step(1);
    s_if.clr_cnt = 1'b0;
    vectors++; if (s_if.fall[3] !== 1'b1) begin miscompares++; $display("FAIL clr_fall: got %b expected %b", s_if.fall[3], 1'b1); end
    vectors++; if (s_if.toggle_cnt[7:6] !== 2'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d expected %0d", s_if.toggle_cnt[7:6], 0); end
    s_if.vip[3] = 1'b1; s_if.vin[3] = 1'b0;
    step(3);
    vectors++; if (s_if.toggle_cnt[7:6] !== 2'd1) begin miscompares++; $display("FAIL clr_recount: got %0d expected %0d", s_if.toggle_cnt[7:6], 1); end
  endtask

  task automatic test_async_reset;
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (m_if.out !== 4'b0000) begin miscompares++; $display("FAIL arst_out: got %b expected %b", m_if.out, 4'b0000); end
    vectors++; if (m_if.valid !== 4'b0000) begin miscompares++; $display("FAIL arst_valid: got %b expected %b", m_if.valid, 4'b0000); end
    vectors++; if (m_if.toggle_cnt !== 32'h0) begin miscompares++; $display("FAIL arst_cnt: got %h expected %h", m_if.toggle_cnt, 32'h0); end
    vectors++; if (s_if.toggle_cnt !== 8'h0) begin miscompares++; $display("FAIL arst_cnt_s: got %h expected %h", s_if.toggle_cnt, 8'h0); end
    #2;
    rst = 1'b0;
    step(1);
    step(4);
    vectors++; if (m_if.out !== 4'b0000) begin miscompares++; $display("FAIL arst_relatch_early: got %b expected %b", m_if.out, 4'b0000); end
    step(1);
    vectors++; if (m_if.out !== 4'b1001) begin miscompares++; $display("FAIL arst_relatch_out: got %b expected %b", m_if.out, 4'b1001); end
    vectors++; if (m_if.valid !== 4'b1011) begin miscompares++; $display("FAIL arst_relatch_valid: got %b expected %b", m_if.valid, 4'b1011); end
    vectors++; if (m_if.rise !== 4'b1001 || m_if.fall !== 4'b0000) begin miscompares++; $display("FAIL arst_relatch_pulses: got rise %b fall %b expected rise 1001 fall 0000", m_if.rise, m_if.fall); end
    vectors++; if (m_if.toggle_cnt[15:0] !== 16'h0001) begin miscompares++; $display("FAIL arst_relatch_cnt: got %h expected %h", m_if.toggle_cnt[15:0], 16'h0001); end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_hold;
    test_enable;
    test_saturation;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
